// File: rtl/parking_todo_queue_if.sv
// Request/job bus between the car-request pins, the intake queue and the
// elevator controller. The master drives requests and todo_done; the slave
// (the queue) presents the pending job and its status flags.
interface parking_todo_queue_if #(
    parameter int PLATE_W = 16
);
    // Request side
    logic [PLATE_W-1:0] license_plate;
    logic               in_mode;
    logic               out_mode;
    logic               leakage;
    logic [2:0]         leakage_floor;
    logic               todo_done;

    // Presented job and status
    logic               todo_exists;
    logic               todo_in;
    logic               todo_out;
    logic               todo_leak_move;
    logic [PLATE_W-1:0] todo_license_plate;
    logic [2:0]         todo_leak_floor;
    logic [4:0]         queue_count;
    logic               overflow;
    logic               req_error;

    modport master (
        output license_plate, in_mode, out_mode, leakage, leakage_floor, todo_done,
        input  todo_exists, todo_in, todo_out, todo_leak_move,
               todo_license_plate, todo_leak_floor, queue_count, overflow, req_error
    );

    modport slave (
        input  license_plate, in_mode, out_mode, leakage, leakage_floor, todo_done,
        output todo_exists, todo_in, todo_out, todo_leak_move,
               todo_license_plate, todo_leak_floor, queue_count, overflow, req_error
    );
endinterface

// File: rtl/parking_todo_queue.sv
// Parking request intake buffer.
// Captures entry/exit request pulses into an ordered FIFO and leakage alarms
// into a single priority slot, and presents exactly one pending job (leak
// first, else FIFO head) to the elevator controller, which retires it with
// todo_done.
// Optional: define PARKING_TODO_DEDUP_EN to reject pushes that duplicate an
// entry already waiting in the FIFO.
module parking_todo_queue #(
    parameter int DEPTH   = 8,
    parameter int PLATE_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    parking_todo_queue_if.slave  bus
);
    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [4:0]     FULL_COUNT = 5'(DEPTH);

    typedef struct packed {
        logic               is_out;
        logic [PLATE_W-1:0] plate;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [4:0]         count;
    logic               leak_full;
    logic [2:0]         leak_floor_q;
    logic               overflow_q;
    logic               req_error_q;

    entry_t             new_entry;
    entry_t             head;
    logic               req_valid;
    logic               req_bad;
    logic               leak_bad;
    logic               leak_load;
    logic               dup_hit;
    logic               pop_leak;
    logic               pop_fifo;
    logic               can_push;
    logic               do_push;
    logic               drop;

    // Classify this cycle's request, pop and leak events.
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        new_entry = '{is_out: bus.out_mode, plate: bus.license_plate};
        req_valid = (bus.in_mode ^ bus.out_mode) && (bus.license_plate != '0);
        req_bad   = (bus.in_mode | bus.out_mode) && !req_valid;
        leak_bad  = bus.leakage && (bus.leakage_floor == 3'd0);
        leak_load = bus.leakage && (bus.leakage_floor != 3'd0) && !leak_full;
        // The leak slot shadows the FIFO, so a pop retires only one of them.
        pop_leak  = bus.todo_done && leak_full;
        pop_fifo  = bus.todo_done && !leak_full && (count != 5'd0);
        // A pop on the same edge frees the slot the push needs.
        can_push  = (count != FULL_COUNT) || pop_fifo;
        do_push   = req_valid && !dup_hit && can_push;
        drop      = req_valid && !dup_hit && !can_push;
    end

`ifdef PARKING_TODO_DEDUP_EN
    // Compare the incoming request against every occupied FIFO slot.
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((5'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) && (mem[i] == new_entry)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // FIFO storage write port.
    // NOTE: storage is not reset; only the pointers and count are, which is enough to mark it empty.
    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy, leak slot and status flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            leak_full    <= 1'b0;
            leak_floor_q <= '0;
            overflow_q   <= 1'b0;
            req_error_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + 5'(do_push) - 5'(pop_fifo);

            // The slot cannot reload on its pop edge, so a held alarm re-arms one edge later.
            if (pop_leak) begin
                leak_full    <= 1'b0;
                leak_floor_q <= '0;
            end else if (leak_load) begin
                leak_full    <= 1'b1;
                leak_floor_q <= bus.leakage_floor;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
            req_error_q <= req_bad || leak_bad || (req_valid && dup_hit);
        end
    end

    // Present the leak job if pending, else the FIFO head, else nothing.
    always_comb begin
        head                   = mem[rd_ptr];
        bus.todo_in            = 1'b0;
        bus.todo_out           = 1'b0;
        bus.todo_leak_move     = 1'b0;
        bus.todo_license_plate = '0;
        bus.todo_leak_floor    = '0;
        if (leak_full) begin
            bus.todo_leak_move  = 1'b1;
            bus.todo_leak_floor = leak_floor_q;
        end else if (count != 5'd0) begin
            bus.todo_in            = !head.is_out;
            bus.todo_out           = head.is_out;
            bus.todo_license_plate = head.plate;
        end
        bus.todo_exists = leak_full || (count != 5'd0);
        bus.queue_count = count;
        bus.overflow    = overflow_q;
        bus.req_error   = req_error_q;
    end
endmodule

// File: tb/tb_parking_todo_queue.sv
// Directed self-checking bench for parking_todo_queue (DEPTH=8, PLATE_W=16).
// Dedup expectations follow PARKING_TODO_DEDUP_EN when it is defined.
module tb_parking_todo_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    parking_todo_queue_if #(.PLATE_W(16)) bus ();

    parking_todo_queue #(.DEPTH(8), .PLATE_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {exists, in, out, leak_move}
    logic [3:0] flags;
    assign flags = {bus.todo_exists, bus.todo_in, bus.todo_out, bus.todo_leak_move};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.license_plate = '0;
        bus.in_mode       = 1'b0;
        bus.out_mode      = 1'b0;
        bus.leakage       = 1'b0;
        bus.leakage_floor = '0;
        bus.todo_done     = 1'b0;
    endtask

    task automatic push(input logic is_out, input logic [15:0] plate);
        bus.in_mode       = !is_out;
        bus.out_mode      = is_out;
        bus.license_plate = plate;
        tick();
        bus.in_mode       = 1'b0;
        bus.out_mode      = 1'b0;
        bus.license_plate = '0;
    endtask

    task automatic pop();
        bus.todo_done = 1'b1;
        tick();
        bus.todo_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        bus.in_mode       = 1'b1;
        bus.license_plate = 16'h1234;
        tick();
        idle();
        n_cmp++; if ({flags, bus.overflow, bus.req_error} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 000000", {flags, bus.overflow, bus.req_error}); end
        n_cmp++; if (bus.queue_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.queue_count); end
        n_cmp++; if ({bus.todo_license_plate, bus.todo_leak_floor} !== 19'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus.todo_license_plate, bus.todo_leak_floor}); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        push(1'b0, 16'h9423);
        n_cmp++; if (flags !== 4'b1100) begin n_bad++; $display("FAIL single_flags: got %b want 1100", flags); end
        n_cmp++; if (bus.todo_license_plate !== 16'h9423) begin n_bad++; $display("FAIL single_plate: got %h want 9423", bus.todo_license_plate); end
        n_cmp++; if (bus.queue_count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.queue_count); end
        pop();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL single_pop_flags: got %b want 0000", flags); end
        n_cmp++; if (bus.queue_count !== 5'd0) begin n_bad++; $display("FAIL single_pop_count: got %0d want 0", bus.queue_count); end
        // todo_done with nothing presented is ignored
        pop();
        n_cmp++; if ({flags, bus.queue_count} !== 9'd0) begin n_bad++; $display("FAIL idle_pop: got %h want 0", {flags, bus.queue_count}); end
    endtask

    task automatic test_mid_reset();
        push(1'b0, 16'h1111);
        push(1'b1, 16'h2222);
        n_cmp++; if (bus.queue_count !== 5'd2) begin n_bad++; $display("FAIL midreset_pre: got %0d want 2", bus.queue_count); end
        do_reset();
        n_cmp++; if ({flags, bus.queue_count} !== 9'd0) begin n_bad++; $display("FAIL midreset_post: got %h want 0", {flags, bus.queue_count}); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            push(1'b0, 16'h1000 + 16'(i));
            if (i == 8) begin
                n_cmp++; if ({bus.queue_count, bus.overflow} !== {5'd8, 1'b0}) begin n_bad++; $display("FAIL ovf_full: got count %0d ovf %b want 8/0", bus.queue_count, bus.overflow); end
            end
        end
        n_cmp++; if ({bus.queue_count, bus.overflow} !== {5'd8, 1'b1}) begin n_bad++; $display("FAIL ovf_drop: got count %0d ovf %b want 8/1", bus.queue_count, bus.overflow); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if ({flags, bus.todo_license_plate} !== {4'b1100, 16'h1000 + 16'(i)}) begin n_bad++; $display("FAIL ovf_order%0d: got %b/%h want 1100/%h", i, flags, bus.todo_license_plate, 16'h1000 + 16'(i)); end
            pop();
        end
        n_cmp++; if ({flags, bus.queue_count, bus.overflow} !== {4'b0, 5'd0, 1'b1}) begin n_bad++; $display("FAIL ovf_sticky: got %b/%0d/%b want 0000/0/1", flags, bus.queue_count, bus.overflow); end
        do_reset();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_leak_priority();
        do_reset();
        push(1'b1, 16'h8754);
        push(1'b0, 16'h5755);
        bus.leakage = 1'b1;
        bus.leakage_floor = 3'd3;
        tick();
        n_cmp++; if (flags !== 4'b1001) begin n_bad++; $display("FAIL leak_flags: got %b want 1001", flags); end
        n_cmp++; if ({bus.todo_leak_floor, bus.todo_license_plate, bus.queue_count} !== {3'd3, 16'h0, 5'd2}) begin n_bad++; $display("FAIL leak_data: got fl %0d pl %h cnt %0d want 3/0/2", bus.todo_leak_floor, bus.todo_license_plate, bus.queue_count); end
        // a second alarm while the slot is full keeps the first floor
        bus.leakage_floor = 3'd5;
        tick();
        idle();
        n_cmp++; if (bus.todo_leak_floor !== 3'd3) begin n_bad++; $display("FAIL leak_keep: got %0d want 3", bus.todo_leak_floor); end
        pop();
        n_cmp++; if ({flags, bus.todo_license_plate, bus.todo_leak_floor, bus.queue_count} !== {4'b1010, 16'h8754, 3'd0, 5'd2}) begin n_bad++; $display("FAIL leak_after: got %b/%h/%0d/%0d want 1010/8754/0/2", flags, bus.todo_license_plate, bus.todo_leak_floor, bus.queue_count); end
        pop();
        n_cmp++; if ({flags, bus.todo_license_plate, bus.queue_count} !== {4'b1100, 16'h5755, 5'd1}) begin n_bad++; $display("FAIL leak_second: got %b/%h/%0d want 1100/5755/1", flags, bus.todo_license_plate, bus.queue_count); end
        pop();
        // floor 0 is rejected
        bus.leakage = 1'b1;
        tick();
        idle();
        n_cmp++; if ({bus.req_error, bus.todo_exists} !== 2'b10) begin n_bad++; $display("FAIL leak_floor0: got err %b exists %b want 1/0", bus.req_error, bus.todo_exists); end
        tick();
        n_cmp++; if (bus.req_error !== 1'b0) begin n_bad++; $display("FAIL leak_err_pulse: got %b want 0", bus.req_error); end
        // held alarm re-arms one edge after its pop
        bus.leakage = 1'b1;
        bus.leakage_floor = 3'd6;
        tick();
        pop();
        n_cmp++; if (bus.todo_exists !== 1'b0) begin n_bad++; $display("FAIL rearm_gap: got %b want 0", bus.todo_exists); end
        tick();
        n_cmp++; if ({flags, bus.todo_leak_floor} !== {4'b1001, 3'd6}) begin n_bad++; $display("FAIL rearm: got %b/%0d want 1001/6", flags, bus.todo_leak_floor); end
        idle();
        pop();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL rearm_done: got %b want 0000", flags); end
    endtask

    task automatic test_reject();
        do_reset();
        bus.in_mode = 1'b1;
        bus.out_mode = 1'b1;
        bus.license_plate = 16'h3851;
        tick();
        idle();
        n_cmp++; if ({bus.req_error, bus.todo_exists, bus.queue_count} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL rej_both: got err %b exists %b cnt %0d want 1/0/0", bus.req_error, bus.todo_exists, bus.queue_count); end
        tick();
        n_cmp++; if (bus.req_error !== 1'b0) begin n_bad++; $display("FAIL rej_pulse: got %b want 0", bus.req_error); end
        push(1'b0, 16'h0000);
        n_cmp++; if ({bus.req_error, bus.queue_count} !== {1'b1, 5'd0}) begin n_bad++; $display("FAIL rej_zero: got err %b cnt %0d want 1/0", bus.req_error, bus.queue_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 8; i++) push(1'b0, 16'h2000 + 16'(i));
        bus.in_mode = 1'b1;
        bus.license_plate = 16'h9522;
        bus.todo_done = 1'b1;
        tick();
        idle();
        n_cmp++; if ({bus.queue_count, bus.overflow} !== {5'd8, 1'b0}) begin n_bad++; $display("FAIL b2b_full: got cnt %0d ovf %b want 8/0", bus.queue_count, bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_plate;
            exp_plate = (i < 7) ? 16'h2002 + 16'(i) : 16'h9522;
            n_cmp++; if (bus.todo_license_plate !== exp_plate) begin n_bad++; $display("FAIL b2b_order%0d: got %h want %h", i, bus.todo_license_plate, exp_plate); end
            pop();
        end
        // one entry: push and pop together, new entry becomes head
        push(1'b0, 16'h3001);
        bus.out_mode = 1'b1;
        bus.license_plate = 16'h3002;
        bus.todo_done = 1'b1;
        tick();
        idle();
        n_cmp++; if ({flags, bus.todo_license_plate, bus.queue_count} !== {4'b1010, 16'h3002, 5'd1}) begin n_bad++; $display("FAIL b2b_one: got %b/%h/%0d want 1010/3002/1", flags, bus.todo_license_plate, bus.queue_count); end
    endtask

    task automatic test_dedup();
        logic [4:0] exp_count;
        logic       exp_err;
        do_reset();
        push(1'b0, 16'h8754);
        push(1'b0, 16'h8754);
`ifdef PARKING_TODO_DEDUP_EN
        exp_count = 5'd1;
        exp_err   = 1'b1;
`else
        exp_count = 5'd2;
        exp_err   = 1'b0;
`endif
        n_cmp++; if ({bus.queue_count, bus.req_error} !== {exp_count, exp_err}) begin n_bad++; $display("FAIL dedup_dup: got cnt %0d err %b want %0d/%b", bus.queue_count, bus.req_error, exp_count, exp_err); end
        // same plate, other direction is a distinct job
        push(1'b1, 16'h8754);
        n_cmp++; if ({bus.queue_count, bus.req_error} !== {exp_count + 5'd1, 1'b0}) begin n_bad++; $display("FAIL dedup_dir: got cnt %0d err %b want %0d/0", bus.queue_count, bus.req_error, exp_count + 5'd1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_single();
        test_mid_reset();
        test_overflow();
        test_leak_priority();
        test_reject();
        test_back_to_back();
        test_dedup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/parking_todo_queue.md
Name: parking_todo_queue

Overview:
- Request intake buffer between the external car-request pins (license_plate, in_mode, out_mode, leakage, leakage_floor) and the elevator controller.
- Captures one-cycle in/out request pulses into an ordered FIFO and captures leakage events into a priority slot.
- Presents exactly one pending job on the todo_* interface.
- The elevator controller consumes that job with a todo_done pulse.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- PLATE_W, 16, license plate width (4 BCD digits).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low.
- license_plate  input  PLATE_W  plate sampled with in_mode/out_mode.
- in_mode  input  1  entry request pulse.
- out_mode  input  1  exit request pulse.
- leakage  input  1  leakage alarm level.
- leakage_floor  input  3  alarmed floor, 1..7.
- todo_done  input  1  consumer pop; head job finished.
- todo_exists  output  1  a job is presented.
- todo_in  output  1  presented job is an entry.
- todo_out  output  1  presented job is an exit.
- todo_leak_move  output  1  presented job is a leakage evacuation.
- todo_license_plate  output  PLATE_W  plate of presented job; 0 for a leak job.
- todo_leak_floor  output  3  floor of the leak job; 0 otherwise.
- queue_count  output  5  FIFO occupancy, leak slot excluded.
- overflow  output  1  sticky flag; a request was dropped while full.
- req_error  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. While reset==0 at a rising edge, all of the following clear to 0 next cycle:
  - FIFO pointers and queue_count.
  - Leak slot.
  - overflow and req_error.
  - All todo_* outputs.
- Reset overrides every other input, including mid-operation; pending jobs are discarded.
- Push condition, sampled at the rising edge: exactly one of in_mode/out_mode is 1 and license_plate != 0. The entry stored is {is_out, plate}.
- Rejection:
  - in_mode & out_mode both 1, or plate == 0 with either mode high: nothing stored.
  - req_error=1 for exactly the next cycle.
- Latency: an accepted push into an empty queue with no leak pending appears on todo_* the cycle after the sampling edge.
- Pop: todo_done=1 at an edge while todo_exists=1 retires the presented job. The next job is visible the following cycle. todo_done while todo_exists=0 is ignored.
- Full, no pop: the push is dropped and overflow sets (sticky until reset). queue_count stays at DEPTH.
- Simultaneous push and pop:
  - Both take effect in the same edge; queue_count is unchanged.
  - This holds when full (no overflow) and when the queue holds 1 entry (the new entry becomes head).
- Leak slot capture: the leak slot loads when all of the following hold:
  - leakage=1;
  - leakage_floor is in 1..7;
  - the slot is empty.
- Leak slot other cases:
  - leakage_floor == 0: ignored, and req_error pulses.
  - Slot already full: further leak events are ignored and the first captured floor is kept.
  - leakage held high after its job is popped re-arms the slot on the next edge (level-sensitive, by design).
- Priority: when the leak slot is full it is presented instead of the FIFO head:
  - todo_leak_move=1, todo_in=0, todo_out=0, todo_license_plate=0, todo_leak_floor=captured floor.
  - todo_done retires the leak slot only; the FIFO is untouched.
- todo_exists = leak slot full OR queue_count != 0. When todo_exists=0, all todo_* outputs are 0.
- todo_in/todo_out/todo_leak_move are mutually exclusive (one-hot when todo_exists, else all 0).
- Pointers wrap modulo DEPTH. queue_count ranges 0..DEPTH.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PARKING_TODO_DEDUP_EN.
- When defined: a push whose {is_out, plate} equals any valid FIFO entry (including the head) is rejected. It is not stored, and req_error pulses.
- When undefined: duplicates are stored normally and there is no comparator logic.

Test Plan:
- Reset low 1 cycle, then in_mode=1 with 16'h9423 for 1 cycle -> next cycle todo_exists=1, todo_in=1, todo_license_plate=16'h9423, queue_count=1. todo_done=1 -> following cycle todo_exists=0, queue_count=0.
- 9 consecutive entry pushes 16'h1001..16'h1009, no pops -> queue_count=8, overflow=1. Then 8 pops return 16'h1001..16'h1008 in order. overflow stays 1 until reset.
- FIFO holds 16'h8754 (out) and 16'h5755 (in); leakage=1, floor=3 for 1 cycle:
  - Next cycle: todo_leak_move=1, todo_leak_floor=3, plate=0, queue_count=2.
  - Pop: todo_out=1, plate=16'h8754.
- in_mode=1 and out_mode=1 with 16'h3851 -> req_error=1 for one cycle, queue_count unchanged, nothing presented.
- Full queue (8), push 16'h9522 with todo_done=1 on the same edge -> queue_count=8, overflow=0, 16'h9522 is the last entry popped.
- With PARKING_TODO_DEDUP_EN: push in 16'h8754 twice -> queue_count=1 and req_error pulses on the second. Without the macro -> queue_count=2.
